// File: rtl/pa_riscv.sv
// Shared types and constants for the RISC-V fetch slice.
// Holds the fetch FSM encoding and the reset-time instruction.
package pa_riscv;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    HOLD  = 2'd2,
    FAULT = 2'd3
  } ty_fetchState;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/pc_next.sv
// Next-PC arithmetic for the fetch stage.
// Sequential PC or branch target, plus a misaligned-target flag.
module pc_next (
  input  logic [31:0] pc,
  input  logic        pc_src,
  input  logic [31:0] imm,
  output logic [31:0] next_pc,
  output logic [31:0] pc_plus4,
  output logic        misaligned
);

  logic [31:0] target;

  // adders wrap modulo 2^32
  always_comb begin
    pc_plus4   = pc + 32'd4;
    target     = pc + imm;
    next_pc    = pc_src ? target : pc_plus4;
    misaligned = (next_pc[1:0] != 2'b00);
  end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: PC owner, single-outstanding imem request,
// instruction register handed to decode.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  output logic        o_imemReq,
  output logic [31:0] o_imemAddr,
  input  logic        i_imemAck,
  input  logic [31:0] i_imemRdata,
  output logic        o_instrValid,
  input  logic        i_instrReady,
  output logic [31:0] o_instruction,
  output logic [31:0] o_pc,
  output logic [31:0] o_pcPlus4,
  input  logic        i_pcSrc,
  input  logic [31:0] i_immediateExtended,
  output logic        o_fetchFault
);

  import pa_riscv::*;

  ty_fetchState state;
  logic [31:0]  pc;
  logic [31:0]  ir;
  logic [31:0]  ir_pc;
  logic [31:0]  next_pc;
  logic         misaligned;

  pc_next u_pc_next (
    .pc         (ir_pc),
    .pc_src     (i_pcSrc),
    .imm        (i_immediateExtended),
    .next_pc    (next_pc),
    .pc_plus4   (o_pcPlus4),
    .misaligned (misaligned)
  );

  // fetch FSM, PC and instruction register
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state <= IDLE;
      pc    <= RESET_PC;
      ir    <= NOP_INSTR;
      ir_pc <= RESET_PC;
    end else begin
      case (state)
        IDLE: state <= REQ;
        REQ: begin
          if (i_imemAck) begin
            ir    <= i_imemRdata;
            ir_pc <= pc;
            state <= HOLD;
          end
        end
        HOLD: begin
          if (i_instrReady) begin
            pc    <= next_pc;
            state <= misaligned ? FAULT : REQ;
          end
        end
        FAULT: state <= FAULT;
        default: state <= IDLE;
      endcase
    end
  end

  // outputs decoded from the registered state
  always_comb begin
    o_imemReq     = (state == REQ);
    o_instrValid  = (state == HOLD);
    o_fetchFault  = (state == FAULT);
    o_imemAddr    = pc;
    o_instruction = ir;
    o_pc          = ir_pc;
  end

endmodule
